// File: rtl/gf2_min_weight_scheduler_if.sv
// -----------------------------------------------------------------------------
// axi_stream_if
// Minimal AXI-Stream bundle carrying the enumerator's solution vectors.
//   tdata  [DATA_WIDTH-1:0]  solution beat
//   tvalid                   beat offered by the enumerator
//   tready                   beat accepted by the scheduler
//   tlast                    beat closes the last solution of a machine
// Modports: master (enumerator side), slave (scheduler side).
// -----------------------------------------------------------------------------
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gf2_min_weight_scheduler.sv
// -----------------------------------------------------------------------------
// gf2_min_weight_scheduler
// Runs the GF(2) solution enumerator once per machine job, computes the
// Hamming weight of every solution vector it streams back, keeps the minimum
// weight per machine and sums those minimums over a puzzle (a run of machines
// terminated by job_last).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   job_valid/ready   machine job handshake from the RREF front-end
//   job_vars          variable count of the offered job (1..MAX_VARS)
//   job_last          offered job is the final machine of the puzzle
//   enum_start        one-cycle start pulse to the enumerator
//   solution_stream   AXI-Stream slave, solution vectors (tdata/tvalid/tready/tlast)
//   machine_min       minimum weight of the last completed machine
//   machine_done      one-cycle pulse, machine_min valid
//   result_total      sum of machine minimums of the completed puzzle
//   result_valid      one-cycle pulse with result_total
//   busy              high whenever the FSM is not in IDLE
//   solution_count    (GF2_MIN_WEIGHT_SCHEDULER_STATS_EN only) solutions seen
//                     in the last machine
//
// Optional feature macro: GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
// -----------------------------------------------------------------------------
module gf2_min_weight_scheduler #(
  parameter int MAX_VARS       = 16,
  parameter int MAX_VARS_W     = $clog2(MAX_VARS + 1),
  parameter int AXI_DATA_WIDTH = 8,
  parameter int TOTAL_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [MAX_VARS_W-1:0] job_vars,
  input  logic                  job_last,
  output logic                  enum_start,
  axi_stream_if.slave           solution_stream,
  output logic [MAX_VARS_W-1:0] machine_min,
  output logic                  machine_done,
  output logic [TOTAL_W-1:0]    result_total,
  output logic                  result_valid,
  output logic                  busy
`ifdef GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
  ,
  output logic [TOTAL_W-1:0]    solution_count
`endif
);

  localparam int W         = AXI_DATA_WIDTH;
  localparam int MAX_BEATS = (MAX_VARS + W - 1) / W;
  localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [MAX_VARS_W-1:0] SENTINEL = MAX_VARS_W'(MAX_VARS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    COLLECT,
    REDUCE,
    EMIT
  } state_t;

  state_t                  state, state_next;
  logic [MAX_VARS_W-1:0]   vars_reg;
  logic                    last_reg;
  logic [MAX_VARS_W-1:0]   min_reg;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [MAX_VARS_W-1:0]   run_weight;
  logic [TOTAL_W-1:0]      acc;
`ifdef GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
  logic [TOTAL_W-1:0]      sol_cnt;
`endif

  // Datapath for the beat currently on the stream.
  logic [W-1:0]            beat_data;
  logic [W-1:0]            beat_masked;
  logic [BEAT_W-1:0]       last_beat_idx;
  logic                    final_beat;
  logic                    close_solution;
  logic [MAX_VARS_W-1:0]   beat_pop;
  logic [MAX_VARS_W-1:0]   sol_weight;
  logic [MAX_VARS_W-1:0]   min_next;
  int                      valid_bits;

  assign beat_data = solution_stream.tdata;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    last_beat_idx = BEAT_W'((int'(vars_reg) + W - 1) / W - 1);
    final_beat    = (beat_cnt == last_beat_idx);
    valid_bits    = int'(vars_reg) - int'(beat_cnt) * W;
    beat_masked   = '0;
    beat_pop      = '0;
    for (int i = 0; i < W; i++) begin
      // Only the final beat of a solution can carry bits beyond vars.
      beat_masked[i] = beat_data[i] & (!final_beat || (i < valid_bits));
      beat_pop       = beat_pop + MAX_VARS_W'(beat_masked[i]);
    end
    sol_weight     = run_weight + beat_pop;
    min_next       = (sol_weight < min_reg) ? sol_weight : min_reg;
    // A tlast on a non-final beat is a protocol error; the solution is closed
    // early with whatever weight it has gathered so far.
    close_solution = final_beat || solution_stream.tlast;
  end

  always_comb begin
    state_next             = state;
    job_ready              = 1'b0;
    enum_start             = 1'b0;
    solution_stream.tready = 1'b0;
    busy                   = 1'b1;
    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) state_next = START;
      end
      START: begin
        enum_start = 1'b1;
        state_next = COLLECT;
      end
      COLLECT: begin
        solution_stream.tready = 1'b1;
        if (solution_stream.tvalid && solution_stream.tlast) state_next = REDUCE;
      end
      REDUCE:  state_next = last_reg ? EMIT : IDLE;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // Everything here is a plain register (no memory arrays), so the whole
  // state is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      vars_reg     <= '0;
      last_reg     <= 1'b0;
      min_reg      <= '0;
      beat_cnt     <= '0;
      run_weight   <= '0;
      acc          <= '0;
      machine_min  <= '0;
      machine_done <= 1'b0;
      result_total <= '0;
      result_valid <= 1'b0;
`ifdef GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
      sol_cnt        <= '0;
      solution_count <= '0;
`endif
    end else begin
      state        <= state_next;
      machine_done <= 1'b0;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            vars_reg <= job_vars;
            last_reg <= job_last;
          end
        end
        START: begin
          min_reg    <= SENTINEL;
          beat_cnt   <= '0;
          run_weight <= '0;
`ifdef GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
          sol_cnt    <= '0;
`endif
        end
        COLLECT: begin
          if (solution_stream.tvalid) begin
            if (close_solution) begin
              min_reg    <= min_next;
              beat_cnt   <= '0;
              run_weight <= '0;
`ifdef GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
              sol_cnt    <= sol_cnt + TOTAL_W'(1);
`endif
              // machine_min is captured on the closing edge so it is already
              // valid during REDUCE, the cycle machine_done is high.
              if (solution_stream.tlast) begin
                machine_min  <= (min_next == SENTINEL) ? '0 : min_next;
                machine_done <= 1'b1;
`ifdef GF2_MIN_WEIGHT_SCHEDULER_STATS_EN
                solution_count <= sol_cnt + TOTAL_W'(1);
`endif
              end
            end else begin
              beat_cnt   <= beat_cnt + BEAT_W'(1);
              run_weight <= sol_weight;
            end
          end
        end
        REDUCE: begin
          acc <= acc + TOTAL_W'(machine_min);
          if (last_reg) begin
            result_total <= acc + TOTAL_W'(machine_min);
            result_valid <= 1'b1;
          end
        end
        EMIT: begin
          acc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
